timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
Programmable sequencer for a mod-M style period counter: holds a period and a repeat count, and runs the counter on command.
- Emits one-cycle ticks every P cycles, in one-shot (R ticks then done) or periodic (until stopped) mode.
- Sits between a control/config master and downstream consumers of a rate tick (UART baud, display scan, debounce sampling).
- Replaces fixed-parameter counters with a run-time configurable, start/stop-controlled one.

Parameters:
N, 16, width of period register and internal counter
C, 8, width of repeat-count register

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
cfg_valid  in  1  config write request
cfg_ready  out  1  config may be accepted this cycle
cfg_period  in  N  period P in cycles
cfg_repeat  in  C  tick count R for one-shot mode
cfg_periodic  in  1  1 = periodic mode, 0 = one-shot mode
start  in  1  begin run (single-cycle pulse expected, level tolerated)
stop  in  1  abort run
busy  out  1  high while in RUN
tick  out  1  period tick, one cycle wide
done  out  1  one-shot completion pulse, one cycle wide
count  out  N  current counter value

Behaviour:
- Reset: clk and rst as decided above (reset rst, asynchronous, active-high; clock clk). On reset:
  - state=IDLE; period, repeat and mode registers = 0.
  - counter=0, remaining-tick counter=0.
  - Outputs: cfg_ready=1, busy=0, tick=0, done=0, count=0.
- States: IDLE (unconfigured), ARMED (configured, stopped), RUN, DONE.
- Config handshake:
  - cfg_ready = (state != RUN).
  - Accepted when cfg_valid && cfg_ready at a clock edge: period, repeat and mode are latched; next state is ARMED; counter cleared.
  - In RUN, cfg_valid is ignored (cfg_ready=0); the master holds its request.
- Effective period Pe = max(cfg_period, 1). Effective repeat Re = max(cfg_repeat, 1).
- Transitions:
  - IDLE: cfg accept -> ARMED. start and stop are ignored.
  - ARMED: cfg accept -> ARMED with new config. Otherwise start -> RUN with counter=0 and remaining=Re. If cfg accept and start occur in the same cycle, config wins and start is dropped.
  - RUN: stop -> ARMED, counter=0, no done. Otherwise, when counter==Pe-1:
    - counter wraps to 0.
    - One-shot mode: remaining decrements; on the final tick (remaining==1) -> DONE.
    - Periodic mode: stay in RUN.
  - RUN, counter < Pe-1: counter+1.
  - DONE: one cycle only, then -> ARMED. Config is retained, so start alone relaunches. A cfg accept in DONE is legal and takes effect (-> ARMED).
- Outputs:
  - tick = (state==RUN && counter==Pe-1). Moore output, decoded from registers, no combinational path from inputs.
  - done = (state==DONE).
  - busy = (state==RUN).
  - count = counter.
- Latency:
  - start sampled at edge k -> RUN from cycle k+1 with count=0.
  - First tick is in cycle k+Pe; successive ticks every Pe cycles.
  - done is high in the cycle after the Re-th tick.
- Stop coinciding with the final tick: tick is still high that cycle (already decoded). Stop wins: -> ARMED, done is not asserted.
- Pe=1: tick is high every RUN cycle and count stays 0.
- Counter arithmetic is modulo 2^N. Counter never exceeds Pe-1.
- Async reset mid-RUN: immediate return to IDLE with all outputs at reset values; configuration is lost.

Optional Feature:
- Macro: TIMER_CTRL_PAUSE_EN
- When defined:
  - Adds input pause (1 bit).
  - While pause=1 in RUN, counter and remaining hold; tick is forced 0; busy stays 1.
  - stop still overrides pause.
  - pause has no effect outside RUN.
- When undefined: no pause port; behaviour is exactly as above.

Test Plan:
- Reset then cfg period=4, repeat=3, one-shot, start -> ticks in cycles 4, 8, 12 after start; done high the cycle after the 3rd tick; then ARMED with cfg_ready=1.
- Periodic, period=5 -> tick every 5 cycles for 10 ticks; stop -> busy=0 next cycle, done never asserted.
- period=0 and period=1, repeat=0 -> Pe=1, Re=1: a single tick in the first RUN cycle, then done.
- cfg_valid held high during RUN -> cfg_ready=0 and config unchanged; config accepted in the first ARMED/DONE cycle.
- Edge cases:
  - stop on the same cycle as the final one-shot tick -> tick=1, no done, state ARMED.
  - cfg and start together in ARMED -> start ignored.
- Assert rst mid-RUN (count=7, period=10) -> outputs immediately 0; start after reset ignored until a new config is accepted. With TIMER_CTRL_PAUSE_EN: pause for 3 cycles mid-period -> tick delayed by exactly 3 cycles.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: configuration / control / status bundle for timer_ctrl.
// The master (control processor) drives config and start/stop; the slave
// (timer_ctrl) returns the handshake ready, run status, tick and count.
// Optional macro TIMER_CTRL_PAUSE_EN adds the pause input.
interface timer_ctrl_if #(
    parameter int N = 16,
    parameter int C = 8
);
    logic         cfg_valid;
    logic         cfg_ready;
    logic [N-1:0] cfg_period;
    logic [C-1:0] cfg_repeat;
    logic         cfg_periodic;
    logic         start;
    logic         stop;
`ifdef TIMER_CTRL_PAUSE_EN
    logic         pause;
`endif
    logic         busy;
    logic         tick;
    logic         done;
    logic [N-1:0] count;

    modport master (
        output cfg_valid, cfg_period, cfg_repeat, cfg_periodic, start, stop,
`ifdef TIMER_CTRL_PAUSE_EN
        output pause,
`endif
        input  cfg_ready, busy, tick, done, count
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_repeat, cfg_periodic, start, stop,
`ifdef TIMER_CTRL_PAUSE_EN
        input  pause,
`endif
        output cfg_ready, busy, tick, done, count
    );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: run-time programmable period/tick sequencer.
// Holds a period P and repeat count R; on start it counts 0..Pe-1 and emits
// a one-cycle tick at each wrap, either R times (one-shot, then a done
// pulse) or until stopped (periodic). A zero period or repeat is treated
// as 1. Config is accepted in any state except RUN.
// Optional macro TIMER_CTRL_PAUSE_EN adds a pause input that freezes the
// counters and masks tick while running.
module timer_ctrl #(
    parameter int N = 16,
    parameter int C = 8
) (
    input  logic        clk,
    input  logic        rst,
    timer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};
    localparam logic [C-1:0] ONE_C = {{(C-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] period_q, period_d;
    logic [C-1:0] repeat_q, repeat_d;
    logic         periodic_q, periodic_d;
    logic [N-1:0] counter_q, counter_d;
    logic [C-1:0] remaining_q, remaining_d;

    logic         tick_q, busy_q, done_q, cfg_ready_q;
    logic         tick_d;
    logic [N-1:0] last_q;
    logic [N-1:0] last_d;
    logic         cfg_accept;
    logic         pause_w;

`ifdef TIMER_CTRL_PAUSE_EN
    assign pause_w = bus.pause;
`else
    assign pause_w = 1'b0;
`endif

    // Terminal count Pe-1 for the current and the about-to-be-loaded period
    // (period 0 behaves as period 1, so its terminal count is 0).
    assign last_q = (period_q == '0) ? '0 : period_q - ONE_N;
    assign last_d = (period_d == '0) ? '0 : period_d - ONE_N;

    assign cfg_accept = bus.cfg_valid && (state_q != RUN);

    // Next-state logic: config wins over start, stop wins over counting.
    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        repeat_d    = repeat_q;
        periodic_d  = periodic_q;
        counter_d   = counter_q;
        remaining_d = remaining_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = ARMED;
                end
                if (cfg_accept) begin
                    period_d   = bus.cfg_period;
                    repeat_d   = bus.cfg_repeat;
                    periodic_d = bus.cfg_periodic;
                    counter_d  = '0;
                    state_d    = ARMED;
                end
            end
            ARMED: begin
                if (cfg_accept) begin
                    period_d   = bus.cfg_period;
                    repeat_d   = bus.cfg_repeat;
                    periodic_d = bus.cfg_periodic;
                    counter_d  = '0;
                end else if (bus.start) begin
                    state_d     = RUN;
                    counter_d   = '0;
                    remaining_d = (repeat_q == '0) ? ONE_C : repeat_q;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d   = ARMED;
                    counter_d = '0;
                end else if (!pause_w) begin
                    if (counter_q == last_q) begin
                        counter_d = '0;
                        if (!periodic_q) begin
                            remaining_d = remaining_q - ONE_C;
                            if (remaining_q == ONE_C) begin
                                state_d = DONE;
                            end
                        end
                    end else begin
                        counter_d = counter_q + ONE_N;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tick is pre-decoded from next state so the output is a flop.
    assign tick_d = (state_d == RUN) && (counter_d == last_d);

    // State, configuration and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            period_q    <= '0;
            repeat_q    <= '0;
            periodic_q  <= 1'b0;
            counter_q   <= '0;
            remaining_q <= '0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            repeat_q    <= repeat_d;
            periodic_q  <= periodic_d;
            counter_q   <= counter_d;
            remaining_q <= remaining_d;
            tick_q      <= tick_d;
            busy_q      <= (state_d == RUN);
            done_q      <= (state_d == DONE);
            cfg_ready_q <= (state_d != RUN);
        end
    end

    // A paused run must not tick; this mask is the only input-to-output path.
    assign bus.tick      = tick_q & ~pause_w;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_ready = cfg_ready_q;
    assign bus.count     = counter_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed plus random stimulus against an elapsed-time
// reference model. While running, the model keeps only the number of
// unpaused cycles since start; count, tick and one-shot completion all
// follow from that number by modulo arithmetic.
module tb_timer_ctrl;
    localparam int N = 16;
    localparam int C = 8;

`ifdef TIMER_CTRL_PAUSE_EN
    localparam bit HAS_PAUSE = 1'b1;
`else
    localparam bit HAS_PAUSE = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst;
    logic pause_v = 1'b0;

    always #5 clk = ~clk;

    timer_ctrl_if #(.N(N), .C(C)) bus ();

    timer_ctrl #(.N(N), .C(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef TIMER_CTRL_PAUSE_EN
    assign bus.pause = pause_v;
`endif

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model
    int m_phase = M_IDLE;
    int m_pe    = 1;
    int m_re    = 1;
    bit m_per   = 1'b0;
    int m_el    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int  cnt_e;
        bit  tick_e;
        cnt_e  = (m_phase == M_RUN) ? (m_el % m_pe) : 0;
        tick_e = (m_phase == M_RUN) && (cnt_e == m_pe - 1) && !(HAS_PAUSE && pause_v);
        chk("busy",      32'(bus.busy),      32'(m_phase == M_RUN));
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_phase != M_RUN));
        chk("done",      32'(bus.done),      32'(m_phase == M_DONE));
        chk("tick",      32'(bus.tick),      32'(tick_e));
        chk("count",     32'(bus.count),     32'(cnt_e));
    endtask

    // Check the current cycle, advance the model by the inputs now applied,
    // then move to just after the next rising edge.
    task automatic step();
        bit accept;
        bit paused;
        check_outputs();
        accept = bus.cfg_valid && (m_phase != M_RUN);
        paused = HAS_PAUSE && pause_v;
        if (accept) begin
            m_pe    = (bus.cfg_period == '0) ? 1 : int'(bus.cfg_period);
            m_re    = (bus.cfg_repeat == '0) ? 1 : int'(bus.cfg_repeat);
            m_per   = bus.cfg_periodic;
            m_phase = M_ARMED;
            $display("cyc=%0d cfg accepted P=%0d R=%0d periodic=%0b", cyc,
                     bus.cfg_period, bus.cfg_repeat, bus.cfg_periodic);
        end else begin
            case (m_phase)
                M_ARMED: if (bus.start) begin
                    m_phase = M_RUN;
                    m_el    = 0;
                    $display("cyc=%0d start Pe=%0d Re=%0d periodic=%0b", cyc, m_pe, m_re, m_per);
                end
                M_RUN: begin
                    if (bus.stop) begin
                        m_phase = M_ARMED;
                        $display("cyc=%0d stop after %0d run cycles", cyc, m_el + 1);
                    end else if (!paused) begin
                        m_el++;
                        if (!m_per && m_el == m_pe * m_re) begin
                            m_phase = M_DONE;
                            $display("cyc=%0d one-shot complete, done expected next", cyc);
                        end
                    end
                end
                M_DONE: m_phase = M_ARMED;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input int p, input int r, input bit per);
        bus.cfg_valid    = 1'b1;
        bus.cfg_period   = N'(p);
        bus.cfg_repeat   = C'(r);
        bus.cfg_periodic = per;
        step();
        bus.cfg_valid    = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.cfg_valid    = 1'b0;
        bus.cfg_period   = '0;
        bus.cfg_repeat   = '0;
        bus.cfg_periodic = 1'b0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // start in IDLE is ignored
        pulse_start();
        run(2);

        // One-shot P=4 R=3: ticks at +4,+8,+12, done at +13
        cfg(4, 3, 1'b0);
        pulse_start();
        run(16);

        // Periodic P=5: ten ticks, then stop
        cfg(5, 0, 1'b1);
        pulse_start();
        run(50);
        pulse_stop();
        run(3);

        // Degenerate periods and repeat
        cfg(0, 0, 1'b0);
        pulse_start();
        run(3);
        cfg(1, 0, 1'b0);
        pulse_start();
        run(3);

        // Config held during RUN: refused until DONE
        cfg(3, 2, 1'b0);
        pulse_start();
        bus.cfg_valid    = 1'b1;
        bus.cfg_period   = N'(2);
        bus.cfg_repeat   = C'(1);
        bus.cfg_periodic = 1'b0;
        run(8);
        bus.cfg_valid    = 1'b0;
        pulse_start();
        run(4);

        // Stop on the final one-shot tick: tick seen, no done
        cfg(2, 2, 1'b0);
        pulse_start();
        run(3);
        pulse_stop();
        run(3);

        // Config and start together in ARMED: start dropped
        bus.start = 1'b1;
        cfg(3, 1, 1'b0);
        bus.start = 1'b0;
        run(3);

        // Async reset mid-RUN at count 7 with period 10
        cfg(10, 0, 1'b1);
        pulse_start();
        run(7);
        check_outputs();
        #2 rst = 1'b1;
        #1;
        m_phase = M_IDLE;
        check_outputs();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        rst = 1'b0;
        $display("cyc=%0d async reset applied mid-run", cyc);
        pulse_start();
        run(3);

        // Pause for 3 cycles mid-period delays the tick by 3
        if (HAS_PAUSE) begin
            cfg(6, 1, 1'b0);
            pulse_start();
            run(2);
            pause_v = 1'b1;
            run(3);
            pause_v = 1'b0;
            run(8);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.cfg_valid    = ($urandom_range(0, 7) == 0);
            bus.cfg_period   = N'($urandom_range(0, 6));
            bus.cfg_repeat   = C'($urandom_range(0, 4));
            bus.cfg_periodic = $urandom_range(0, 1) == 1;
            bus.start        = ($urandom_range(0, 5) == 0);
            bus.stop         = ($urandom_range(0, 19) == 0);
            pause_v          = HAS_PAUSE && ($urandom_range(0, 4) == 0);
            step();
        end
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        pause_v       = 1'b0;
        run(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
